// File: rtl/adc_pkg.sv
// Shared constants and helpers for the flash ADC digital back-end.
package adc_pkg;

    localparam int ADC_THERM_W_DEF  = 15;
    localparam int ADC_AVG_LOG2_DEF = 2;

    // Width needed to hold a thermometer count from 0 to therm_w inclusive.
    function automatic int adc_code_w(input int therm_w);
        return $clog2(therm_w + 1);
    endfunction

endpackage

// File: rtl/therm_bubble_encoder.sv
// Combinational thermometer-to-binary encoder with bubble flagging.
// Define ADC_BUBBLE_CORRECT_EN to insert 3-input majority correction ahead of encoding.
module therm_bubble_encoder
    import adc_pkg::*;
#(
    parameter int THERM_W = ADC_THERM_W_DEF,
    localparam int OUT_W  = adc_code_w(THERM_W)
) (
    input  logic [THERM_W-1:0] i_therm,
    output logic [OUT_W-1:0]   o_code,
    output logic               o_bad
);

    logic [THERM_W-1:0] w_corr;
    logic               w_seen_zero;

`ifdef ADC_BUBBLE_CORRECT_EN
    // Pad with an implied 1 below bit 0 and an implied 0 above the top bit.
    logic [THERM_W+1:0] w_ext;
    assign w_ext = {1'b0, i_therm, 1'b1};

    always_comb begin
        w_corr = '0;
        for (int i = 0; i < THERM_W; i++) begin
            w_corr[i] = (w_ext[i]   & w_ext[i+1]) |
                        (w_ext[i]   & w_ext[i+2]) |
                        (w_ext[i+1] & w_ext[i+2]);
        end
    end
`else
    assign w_corr = i_therm;
`endif

    // NOTE: combinational logic uses blocking '=' with every output given a default
    // at the top, so each path assigns it and no latch is inferred.
    always_comb begin
        o_code      = '0;
        o_bad       = 1'b0;
        w_seen_zero = 1'b0;
        for (int i = 0; i < THERM_W; i++) begin
            if (!w_corr[i]) begin
                w_seen_zero = 1'b1;
            end else if (w_seen_zero) begin
                o_bad = 1'b1;
            end else begin
                o_code = o_code + OUT_W'(1);
            end
        end
    end

endmodule

// File: rtl/flash_adc_encoder.sv
// Flash ADC back-end: 2-flop sync, bubble-aware encode, 2^AVG_LOG2 averaging, valid/ready output.
// Optional majority bubble correction is enabled by defining ADC_BUBBLE_CORRECT_EN.
module flash_adc_encoder
    import adc_pkg::*;
#(
    parameter int THERM_W  = ADC_THERM_W_DEF,
    parameter int AVG_LOG2 = ADC_AVG_LOG2_DEF,
    localparam int OUT_W   = adc_code_w(THERM_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [THERM_W-1:0] therm_in,
    input  logic               sample_en,
    input  logic               clr,
    output logic [OUT_W-1:0]   code_out,
    output logic               code_valid,
    input  logic               code_ready,
    output logic               bubble_err,
    output logic               overrun
);

    localparam int ACC_W = OUT_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [THERM_W-1:0] r_sync1;
    logic [THERM_W-1:0] r_sync2;
    logic               r_s1_valid;
    logic [OUT_W-1:0]   r_s1_code;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [OUT_W-1:0]   r_code_out;
    logic               r_code_valid;
    logic               r_bubble_err;
    logic               r_overrun;

    logic [OUT_W-1:0]   w_code;
    logic               w_bad;
    logic [ACC_W-1:0]   w_sum;
    logic               w_last;
    logic               w_land;
    logic [OUT_W-1:0]   w_result;

    therm_bubble_encoder #(
        .THERM_W (THERM_W)
    ) u_encoder (
        .i_therm (r_sync2),
        .o_code  (w_code),
        .o_bad   (w_bad)
    );

    assign w_sum    = r_acc + ACC_W'(r_s1_code);
    assign w_last   = (r_count == CNT_LAST);
    assign w_land   = r_s1_valid && w_last && !clr;
    assign w_result = OUT_W'(w_sum >> AVG_LOG2);

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    // NOTE: every register here is reset, including the datapath, because the reset
    // state of the synchroniser, stage 1 and the accumulator is observable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= therm_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_code    <= '0;
            r_bubble_err <= 1'b0;
        end else begin
            r_s1_valid <= sample_en && !clr;
            if (sample_en) begin
                r_s1_code <= w_code;
            end
            if (clr) begin
                r_bubble_err <= 1'b0;
            end else if (sample_en && w_bad) begin
                r_bubble_err <= 1'b1;
            end
        end
    end

    // The completing sample is summed combinationally, so acc never holds a full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (r_s1_valid) begin
            if (w_last) begin
                r_acc   <= '0;
                r_count <= '0;
            end else begin
                r_acc   <= w_sum;
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code_out   <= '0;
            r_code_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_land) begin
                r_code_out   <= w_result;
                r_code_valid <= 1'b1;
            end else if (r_code_valid && code_ready) begin
                r_code_valid <= 1'b0;
            end
            if (clr) begin
                r_overrun <= 1'b0;
            end else if (w_land && r_code_valid && !code_ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign code_out   = r_code_out;
    assign code_valid = r_code_valid;
    assign bubble_err = r_bubble_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_flash_adc_encoder.sv
// Directed bench for flash_adc_encoder: default instance (15 comparators, 4-sample average)
// plus a small instance (3 comparators, no averaging) for the back-to-back case.
module tb_flash_adc_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] therm_in;
    logic        sample_en;
    logic        clr;
    logic [3:0]  code_out;
    logic        code_valid;
    logic        code_ready;
    logic        bubble_err;
    logic        overrun;

    logic [2:0]  therm_s;
    logic        sample_en_s;
    logic        clr_s;
    logic [1:0]  code_out_s;
    logic        code_valid_s;
    logic        code_ready_s;
    logic        bubble_err_s;
    logic        overrun_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    flash_adc_encoder #(
        .THERM_W  (15),
        .AVG_LOG2 (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .therm_in   (therm_in),
        .sample_en  (sample_en),
        .clr        (clr),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .bubble_err (bubble_err),
        .overrun    (overrun)
    );

    flash_adc_encoder #(
        .THERM_W  (3),
        .AVG_LOG2 (0)
    ) dut_s (
        .clk        (clk),
        .rst        (rst),
        .therm_in   (therm_s),
        .sample_en  (sample_en_s),
        .clr        (clr_s),
        .code_out   (code_out_s),
        .code_valid (code_valid_s),
        .code_ready (code_ready_s),
        .bubble_err (bubble_err_s),
        .overrun    (overrun_s)
    );

    typedef struct {
        string           name;
        logic [3:0][14:0] words;
        logic [3:0]      exp_code;
        logic            exp_bub;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word, let it cross the synchroniser, then strobe one conversion.
    // Returns just after the edge that loads stage 1.
    task automatic do_sample(input logic [14:0] w);
        therm_in = w;
        tick();
        tick();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"avg_3",     {15'h0007, 15'h0007, 15'h0007, 15'h0007}, 4'd3,  1'b0};
        vecs[1] = '{"avg_3445",  {15'h001F, 15'h000F, 15'h000F, 15'h0007}, 4'd4,  1'b0};
        vecs[2] = '{"avg_trunc", {15'h7FFF, 15'h0000, 15'h0000, 15'h0000}, 4'd3,  1'b0};
        vecs[3] = '{"all_zero",  {15'h0000, 15'h0000, 15'h0000, 15'h0000}, 4'd0,  1'b0};
        vecs[4] = '{"all_ones",  {15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF}, 4'd15, 1'b0};
`ifdef ADC_BUBBLE_CORRECT_EN
        vecs[5] = '{"bub_000B",  {15'h000B, 15'h000B, 15'h000B, 15'h000B}, 4'd3,  1'b0};
`else
        vecs[5] = '{"bub_000B",  {15'h000B, 15'h000B, 15'h000B, 15'h000B}, 4'd2,  1'b1};
`endif
        vecs[6] = '{"bub_00F1",  {15'h00F1, 15'h00F1, 15'h00F1, 15'h00F1}, 4'd1,  1'b1};

        rst          = 1'b1;
        therm_in     = '0;
        sample_en    = 1'b0;
        clr          = 1'b0;
        code_ready   = 1'b1;
        therm_s      = '0;
        sample_en_s  = 1'b0;
        clr_s        = 1'b0;
        code_ready_s = 1'b1;
        #12;
        check("reset_code_out",   code_out,   0);
        check("reset_code_valid", code_valid, 0);
        check("reset_bubble_err", bubble_err, 0);
        check("reset_overrun",    overrun,    0);
        rst = 1'b0;
        tick();

        // Table: four conversions per vector, result visible two edges after the last strobe.
        for (int v = 0; v < 7; v++) begin
            pulse_clr();
            for (int k = 0; k < 4; k++) begin
                do_sample(vecs[v].words[k]);
            end
            check({vecs[v].name, "_valid_early"}, code_valid, 0);
            tick();
            check({vecs[v].name, "_valid"}, code_valid, 1);
            check({vecs[v].name, "_code"},  code_out,   vecs[v].exp_code);
            check({vecs[v].name, "_bub"},   bubble_err, vecs[v].exp_bub);
            check({vecs[v].name, "_ovr"},   overrun,    0);
            tick();
            check({vecs[v].name, "_consumed"}, code_valid, 0);
        end

        // clr drops the sticky flag, and beats a same-cycle bad word.
        pulse_clr();
        check("clr_bubble", bubble_err, 0);
        therm_in = 15'h00F1;
        tick();
        tick();
        sample_en = 1'b1;
        clr       = 1'b1;
        tick();
        sample_en = 1'b0;
        clr       = 1'b0;
        check("clr_wins_bubble", bubble_err, 0);
        tick();
        check("clr_wins_no_result", code_valid, 0);

        // Backpressure: second result overwrites the first and flags overrun.
        code_ready = 1'b0;
        for (int k = 0; k < 4; k++) do_sample(15'h0003);
        tick();
        check("bp_first_valid", code_valid, 1);
        check("bp_first_code",  code_out,   2);
        check("bp_first_ovr",   overrun,    0);
        for (int k = 0; k < 4; k++) do_sample(15'h003F);
        tick();
        check("bp_second_code",  code_out,   6);
        check("bp_second_valid", code_valid, 1);
        check("bp_overrun",      overrun,    1);
        code_ready = 1'b1;
        tick();
        check("bp_drained",       code_valid, 0);
        check("bp_overrun_stick", overrun,    1);

        // New result landing on a transfer cycle is not an overrun.
        pulse_clr();
        check("xfer_clr_ovr", overrun, 0);
        code_ready = 1'b0;
        for (int k = 0; k < 4; k++) do_sample(15'h0001);
        tick();
        check("xfer_hold_code", code_out, 1);
        for (int k = 0; k < 4; k++) do_sample(15'h0007);
        code_ready = 1'b1;
        tick();
        check("xfer_land_valid", code_valid, 1);
        check("xfer_land_code",  code_out,   3);
        check("xfer_land_ovr",   overrun,    0);
        tick();
        check("xfer_drained", code_valid, 0);

        // Abort a partial average with clr, including the sample still in stage 1.
        do_sample(15'h7FFF);
        do_sample(15'h7FFF);
        pulse_clr();
        for (int k = 0; k < 4; k++) do_sample(15'h0001);
        tick();
        check("abort_clr_valid", code_valid, 1);
        check("abort_clr_code",  code_out,   1);

        // Abort with an asynchronous reset while outputs and flags are all non-zero.
        code_ready = 1'b0;
        for (int k = 0; k < 4; k++) do_sample(15'h00F1);
        for (int k = 0; k < 4; k++) do_sample(15'h0007);
        tick();
        check("pre_rst_ovr", overrun, 1);
        do_sample(15'h7FFF);
        do_sample(15'h7FFF);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_code",  code_out,   0);
        check("async_rst_valid", code_valid, 0);
        check("async_rst_bub",   bubble_err, 0);
        check("async_rst_ovr",   overrun,    0);
        #2;
        rst = 1'b0;
        code_ready = 1'b1;
        for (int k = 0; k < 4; k++) do_sample(15'h0001);
        tick();
        check("abort_rst_valid", code_valid, 1);
        check("abort_rst_code",  code_out,   1);

        // No averaging: back-to-back strobes give one result per cycle, three edges behind.
        sample_en_s = 1'b1;
        therm_s = 3'h1;
        tick();
        therm_s = 3'h3;
        tick();
        therm_s = 3'h7;
        tick();
        therm_s = 3'h0;
        tick();
        check("small_r0_code",  code_out_s,   1);
        check("small_r0_valid", code_valid_s, 1);
        tick();
        check("small_r1_code",  code_out_s,   2);
        tick();
        check("small_r2_code",  code_out_s,   3);
        tick();
        check("small_r3_code",  code_out_s,   0);
        check("small_valid",    code_valid_s, 1);
        check("small_overrun",  overrun_s,    0);
        sample_en_s = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
